// File: rtl/choose_pivot_column.sv
// Simplex pivot-column selector: scans the FP32 objective row and reports the most negative coefficient.
// Define BLAND_RULE_EN to select the first negative coefficient (Bland anti-cycling) instead.
module choose_pivot_column #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_cols,
  input  logic [DATA_W-1:0] s_axis_obj_tdata,
  input  logic              s_axis_obj_tvalid,
  output logic              s_axis_obj_tready,
  input  logic              s_axis_obj_tlast,
  output logic [IDX_W-1:0]  m_axis_pivot_col_idx,
  output logic [DATA_W-1:0] m_axis_pivot_col_val,
  output logic              m_axis_pivot_col_tvalid,
  input  logic              m_axis_pivot_col_tready,
  output logic              optimal,
  output logic              error,
  output logic              busy
);

  localparam int MAG_W = DATA_W - 1;
  localparam int EXP_W = 8;
  localparam int MAN_W = DATA_W - 1 - EXP_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_RESULT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   num_cols_q, num_cols_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [DATA_W-1:0]  best_val_q, best_val_d;
  logic               found_q, found_d;
  logic               error_q, error_d;

  logic               in_ready;
  logic               beat;
  logic [IDX_W-1:0]   last_col;
  logic               at_last_col;
  logic               is_nan;
  logic               is_neg;
  logic               is_cand;
  logic               take_new;

  always_comb begin
    in_ready    = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    beat        = s_axis_obj_tvalid && in_ready;
    last_col    = num_cols_q - IDX_W'(1);
    at_last_col = (count_q == last_col);
    is_nan      = (s_axis_obj_tdata[DATA_W-2 -: EXP_W] == '1) &&
                  (s_axis_obj_tdata[MAN_W-1:0] != '0);
    // -0.0 has a zero magnitude and so never qualifies; -Inf is a legal candidate
    is_neg      = s_axis_obj_tdata[DATA_W-1] &&
                  (s_axis_obj_tdata[MAG_W-1:0] != '0) && !is_nan;
    is_cand     = is_neg && (count_q < last_col);
`ifdef BLAND_RULE_EN
    take_new    = is_cand && !found_q;
`else
    take_new    = is_cand &&
                  (!found_q || (s_axis_obj_tdata[MAG_W-1:0] > best_val_q[MAG_W-1:0]));
`endif
  end

  always_comb begin
    state_d    = state_q;
    num_cols_d = num_cols_q;
    count_d    = count_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    found_d    = found_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_cols_d = num_cols;
          count_d    = '0;
          best_idx_d = '0;
          best_val_d = '0;
          found_d    = 1'b0;
          error_d    = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (beat) begin
          count_d = count_q + IDX_W'(1);
          if (take_new) begin
            best_idx_d = count_q;
            best_val_d = s_axis_obj_tdata;
            found_d    = 1'b1;
          end
          if (at_last_col) begin
            if (s_axis_obj_tlast) begin
              state_d = ST_RESULT;
            end else begin
              error_d = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (s_axis_obj_tlast) begin
            error_d = 1'b1;
            state_d = ST_RESULT;
          end
        end
      end
      ST_DRAIN: begin
        if (beat && s_axis_obj_tlast) begin
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (m_axis_pivot_col_tready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      num_cols_q <= '0;
      count_q    <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      found_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_cols_q <= num_cols_d;
      count_q    <= count_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      found_q    <= found_d;
      error_q    <= error_d;
    end
  end

  // All outputs come from registers only, so no input reaches an output combinationally
  always_comb begin
    s_axis_obj_tready       = in_ready;
    m_axis_pivot_col_tvalid = (state_q == ST_RESULT);
    m_axis_pivot_col_idx    = best_idx_q;
    m_axis_pivot_col_val    = best_val_q;
    optimal                 = (state_q == ST_RESULT) && !found_q;
    error                   = (state_q == ST_RESULT) && error_q;
    busy                    = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_choose_pivot_column.sv
// Scoreboard bench for choose_pivot_column: directed rows, expected results queued, monitor compares.
module tb_choose_pivot_column;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_cols;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [15:0] p_idx;
  logic [31:0] p_val;
  logic        p_tvalid;
  logic        m_ready;
  logic        optimal;
  logic        error;
  logic        busy;

  typedef struct packed {
    logic [15:0] idx;
    logic [31:0] val;
    logic        opt;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] row_mem[0:15];

  choose_pivot_column #(.DATA_W(32), .IDX_W(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .num_cols                (num_cols),
    .s_axis_obj_tdata        (s_tdata),
    .s_axis_obj_tvalid       (s_tvalid),
    .s_axis_obj_tready       (s_tready),
    .s_axis_obj_tlast        (s_tlast),
    .m_axis_pivot_col_idx    (p_idx),
    .m_axis_pivot_col_val    (p_val),
    .m_axis_pivot_col_tvalid (p_tvalid),
    .m_axis_pivot_col_tready (m_ready),
    .optimal                 (optimal),
    .error                   (error),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge clk) begin
    #2;
    if (p_tvalid === 1'b1 && m_ready === 1'b1) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_idx", {16'h0, p_idx}, {16'h0, e.idx});
        chk("result_val", p_val, e.val);
        chk("result_optimal", {31'h0, optimal}, {31'h0, e.opt});
        chk("result_error", {31'h0, error}, {31'h0, e.err});
      end
    end
  end

  task automatic push_exp(input logic [15:0] idx, input logic [31:0] val,
                          input logic opt, input logic err);
    exp_t e;
    e.idx = idx;
    e.val = val;
    e.opt = opt;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] n);
    @(negedge clk);
    start    = 1'b1;
    num_cols = n;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_row(input int nb, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(negedge clk);
          s_tvalid = 1'b0;
        end
      end
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = row_mem[i];
      s_tlast  = (i == nb - 1);
      begin
        int w;
        w = 0;
        while (s_tready !== 1'b1 && w < 50) begin
          @(negedge clk);
          w++;
        end
        if (w >= 50) fail_now("tready_wait");
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    #1 chk("latency_tvalid", {31'h0, p_tvalid}, 32'h1);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      #3;
      w++;
    end while ((busy !== 1'b0 || sb.size() != 0) && w < 100);
    if (w >= 100) fail_now("wait_idle");
  endtask

  task automatic load_t1();
    row_mem[0] = 32'h40000000;
    row_mem[1] = 32'hBF800000;
    row_mem[2] = 32'hC0400000;
    row_mem[3] = 32'hC0400000;
    row_mem[4] = 32'h40800000;
  endtask

  task automatic push_t1();
`ifdef BLAND_RULE_EN
    push_exp(16'd1, 32'hBF800000, 1'b0, 1'b0);
`else
    push_exp(16'd2, 32'hC0400000, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    num_cols = '0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_tready", {31'h0, s_tready}, 32'h0);
    chk("reset_tvalid", {31'h0, p_tvalid}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_optimal", {31'h0, optimal}, 32'h0);
    chk("reset_error", {31'h0, error}, 32'h0);
    chk("reset_idx", {16'h0, p_idx}, 32'h0);
    chk("reset_val", p_val, 32'h0);
    reset = 1'b0;

    // T1: most negative with a tie at columns 2/3
    load_t1();
    push_t1();
    do_start(16'd5);
    send_row(5, 1'b0);
    wait_idle();

    // T2: no negative candidate; -0.0 ignored, negative RHS ignored
    row_mem[0] = 32'h3F800000;
    row_mem[1] = 32'h80000000;
    row_mem[2] = 32'h00000000;
    row_mem[3] = 32'hC0A00000;
    push_exp(16'd0, 32'h0, 1'b1, 1'b0);
    do_start(16'd4);
    send_row(4, 1'b0);
    wait_idle();

    // T3: backpressure on the result
    load_t1();
    push_t1();
    m_ready = 1'b0;
    do_start(16'd5);
    send_row(5, 1'b0);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("hold_tvalid", {31'h0, p_tvalid}, 32'h1);
`ifdef BLAND_RULE_EN
      chk("hold_idx", {16'h0, p_idx}, 32'd1);
      chk("hold_val", p_val, 32'hBF800000);
`else
      chk("hold_idx", {16'h0, p_idx}, 32'd2);
      chk("hold_val", p_val, 32'hC0400000);
`endif
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    #3;
    chk("post_hs_busy", {31'h0, busy}, 32'h0);
    chk("post_hs_tvalid", {31'h0, p_tvalid}, 32'h0);
    wait_idle();

    // T4a: early tlast
    row_mem[0] = 32'hBF800000;
    row_mem[1] = 32'h40000000;
    row_mem[2] = 32'hC0000000;
`ifdef BLAND_RULE_EN
    push_exp(16'd0, 32'hBF800000, 1'b0, 1'b1);
`else
    push_exp(16'd2, 32'hC0000000, 1'b0, 1'b1);
`endif
    do_start(16'd5);
    send_row(3, 1'b0);
    wait_idle();

    // T4b: missing tlast at RHS, two beats drained
    row_mem[0] = 32'h40000000;
    row_mem[1] = 32'hC0000000;
    row_mem[2] = 32'hC1000000;
    row_mem[3] = 32'hBF800000;
    row_mem[4] = 32'hC2000000;
    push_exp(16'd1, 32'hC0000000, 1'b0, 1'b1);
    do_start(16'd3);
    send_row(5, 1'b0);
    wait_idle();

    // T5: reset mid-scan, then a fresh T1 row
    load_t1();
    do_start(16'd5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = row_mem[i];
      s_tlast  = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_tready", {31'h0, s_tready}, 32'h0);
    chk("abort_tvalid", {31'h0, p_tvalid}, 32'h0);
    push_t1();
    do_start(16'd5);
    send_row(5, 1'b0);
    wait_idle();

    // T6: tvalid gaps and a positive NaN at column 0
    load_t1();
    row_mem[0] = 32'h7FC00000;
    push_t1();
    do_start(16'd5);
    send_row(5, 1'b1);
    wait_idle();

    // T7: -Inf beats the largest finite negative
    row_mem[0] = 32'hFF7FFFFF;
    row_mem[1] = 32'hFF800000;
    row_mem[2] = 32'hC0000000;
    row_mem[3] = 32'h00000000;
`ifdef BLAND_RULE_EN
    push_exp(16'd0, 32'hFF7FFFFF, 1'b0, 1'b0);
`else
    push_exp(16'd1, 32'hFF800000, 1'b0, 1'b0);
`endif
    do_start(16'd4);
    send_row(4, 1'b0);
    wait_idle();

    // T8: sign-set NaN is never a candidate
    row_mem[0] = 32'hFFC00000;
    row_mem[1] = 32'hBF800000;
    row_mem[2] = 32'h00000000;
    push_exp(16'd1, 32'hBF800000, 1'b0, 1'b0);
    do_start(16'd3);
    send_row(3, 1'b0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
